// File: rtl/otbn_bignum_wb_sched.sv
// Write-back scheduler for the dual-port wide register file (WDRs).
// Arbitrates NReq result producers onto write ports A and B every cycle,
// refuses lane-overlapping same-register pairs, registers the winning writes
// with pre-decoded one-hot strobes, and keeps a sticky error flag.
module otbn_bignum_wb_sched #(
  parameter int NReq    = 3,
  parameter int MaxWait = 4,
  parameter int NWdr    = 32,
  parameter int WdrAw   = 5,
  parameter int ExtWLEN = 312
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    stall_i,

  input  logic [NReq-1:0]         req_valid_i,
  output logic [NReq-1:0]         req_ready_o,
  input  logic [NReq*WdrAw-1:0]   req_addr_i,
  input  logic [NReq*8-1:0]       req_lane_i,
  input  logic [NReq*ExtWLEN-1:0] req_data_i,

  output logic [WdrAw-1:0]        wr_addr_a_o,
  output logic [7:0]              wr_en_a_o,
  output logic [ExtWLEN-1:0]      wr_data_a_o,
  output logic [NWdr-1:0]         rf_we_a_o,

  output logic [WdrAw-1:0]        wr_addr_b_o,
  output logic [7:0]              wr_en_b_o,
  output logic [ExtWLEN-1:0]      wr_data_b_o,
  output logic [NWdr-1:0]         rf_we_b_o,

  input  logic                    rf_we_err_i,
  output logic                    err_o,
  output logic                    busy_o
);

  localparam int IdxW  = (NReq > 1) ? $clog2(NReq) : 1;
  localparam int WaitW = 4;

  typedef logic [IdxW-1:0] idx_t;

  // Per-requester views of the flattened request buses.
  logic [WdrAw-1:0]   addr_arr [NReq];
  logic [7:0]         lane_arr [NReq];
  logic [ExtWLEN-1:0] data_arr [NReq];

  for (genvar g = 0; g < NReq; g++) begin : g_unpack
    assign addr_arr[g] = req_addr_i[g*WdrAw +: WdrAw];
    assign lane_arr[g] = req_lane_i[g*8 +: 8];
    assign data_arr[g] = req_data_i[g*ExtWLEN +: ExtWLEN];
  end

  // Scheduler state.
  idx_t             rr_ptr;
  logic [WaitW-1:0] wait_cnt [NReq];

  // Arbitration results.
  idx_t order [NReq];
  logic force_hit;
  idx_t force_idx;
  logic gnt_a_vld, gnt_b_vld;
  idx_t gnt_a_idx, gnt_b_idx;
  logic grant_ok, a_go, b_go;

  function automatic logic [NWdr-1:0] addr_onehot(input logic [WdrAw-1:0] a);
    logic [NWdr-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  function automatic logic is_onehot(input logic [NWdr-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic idx_t idx_inc(input idx_t i);
    return (i == idx_t'(NReq - 1)) ? '0 : i + 1'b1;
  endfunction

  // Candidate order: a starved requester (lowest index first) leads, then
  // the remaining requesters in round-robin order from rr_ptr.
  // NOTE: every variable written in a combinational block gets a default at
  // the top; a path that leaves one unassigned would infer a latch.
  always_comb begin
    int   cand;
    idx_t pos;
    cand      = 0;
    pos       = '0;
    force_hit = 1'b0;
    force_idx = '0;
    for (int k = 0; k < NReq; k++) order[k] = '0;

    for (int r = NReq - 1; r >= 0; r--) begin
      if (wait_cnt[r] == WaitW'(MaxWait)) begin
        force_hit = 1'b1;
        force_idx = idx_t'(r);
      end
    end

    if (force_hit) begin
      order[0] = force_idx;
      pos      = idx_t'(1);
    end

    for (int k = 0; k < NReq; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NReq) cand = cand - NReq;
      if (!(force_hit && (cand == int'(force_idx)))) begin
        order[pos] = idx_t'(cand);
        pos        = pos + 1'b1;
      end
    end
  end

  // Port selection: first valid nonzero-mask candidate takes A, the next one
  // that does not overlap A's lanes on the same register takes B.
  always_comb begin
    idx_t c;
    c         = '0;
    gnt_a_vld = 1'b0;
    gnt_a_idx = '0;
    gnt_b_vld = 1'b0;
    gnt_b_idx = '0;
    for (int k = 0; k < NReq; k++) begin
      c = order[k];
      if (req_valid_i[c] && (lane_arr[c] != 8'h00)) begin
        if (!gnt_a_vld) begin
          gnt_a_vld = 1'b1;
          gnt_a_idx = c;
        end else if (!gnt_b_vld &&
                     !((addr_arr[c] == addr_arr[gnt_a_idx]) &&
                       ((lane_arr[c] & lane_arr[gnt_a_idx]) != 8'h00))) begin
          gnt_b_vld = 1'b1;
          gnt_b_idx = c;
        end
      end
    end
  end

  assign grant_ok = !rst_i && !stall_i;
  assign a_go     = grant_ok && gnt_a_vld;
  assign b_go     = grant_ok && gnt_b_vld;

  // Handshake: zero-mask requests are accepted whenever granting is allowed;
  // writing requests only when they won a port.
  always_comb begin
    req_ready_o = '0;
    for (int r = 0; r < NReq; r++) begin
      req_ready_o[r] = grant_ok && req_valid_i[r] &&
                       ((lane_arr[r] == 8'h00) ||
                        (gnt_a_vld && (gnt_a_idx == idx_t'(r))) ||
                        (gnt_b_vld && (gnt_b_idx == idx_t'(r))));
    end
  end

  // Registered port A/B writes; ungranted ports are fully blanked.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_addr_a_o <= '0;
      wr_en_a_o   <= '0;
      wr_data_a_o <= '0;
      rf_we_a_o   <= '0;
      wr_addr_b_o <= '0;
      wr_en_b_o   <= '0;
      wr_data_b_o <= '0;
      rf_we_b_o   <= '0;
    end else begin
      if (a_go) begin
        wr_addr_a_o <= addr_arr[gnt_a_idx];
        wr_en_a_o   <= lane_arr[gnt_a_idx];
        wr_data_a_o <= data_arr[gnt_a_idx];
        rf_we_a_o   <= addr_onehot(addr_arr[gnt_a_idx]);
      end else begin
        wr_addr_a_o <= '0;
        wr_en_a_o   <= '0;
        wr_data_a_o <= '0;
        rf_we_a_o   <= '0;
      end
      if (b_go) begin
        wr_addr_b_o <= addr_arr[gnt_b_idx];
        wr_en_b_o   <= lane_arr[gnt_b_idx];
        wr_data_b_o <= data_arr[gnt_b_idx];
        rf_we_b_o   <= addr_onehot(addr_arr[gnt_b_idx]);
      end else begin
        wr_addr_b_o <= '0;
        wr_en_b_o   <= '0;
        wr_data_b_o <= '0;
        rf_we_b_o   <= '0;
      end
    end
  end

  // Round-robin pointer moves past the last requester that won a port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (b_go) begin
      rr_ptr <= idx_inc(gnt_b_idx);
    end else if (a_go) begin
      rr_ptr <= idx_inc(gnt_a_idx);
    end
  end

  // Wait counters: count refused cycles of a valid request, saturating.
  always_ff @(posedge clk_i) begin
    for (int r = 0; r < NReq; r++) begin
      if (rst_i || !req_valid_i[r] || req_ready_o[r]) begin
        wait_cnt[r] <= '0;
      end else if (wait_cnt[r] != WaitW'(MaxWait)) begin
        wait_cnt[r] <= wait_cnt[r] + 1'b1;
      end
    end
  end

  // Sticky error: register-file report or a malformed strobe on an active port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (rf_we_err_i ||
                 ((wr_en_a_o != 8'h00) && !is_onehot(rf_we_a_o)) ||
                 ((wr_en_b_o != 8'h00) && !is_onehot(rf_we_b_o))) begin
      err_o <= 1'b1;
    end
  end

  assign busy_o = !rst_i &&
                  ((|req_valid_i) || (wr_en_a_o != 8'h00) || (wr_en_b_o != 8'h00));

endmodule

// File: doc/otbn_bignum_wb_sched.md
Name: otbn_bignum_wb_sched

Overview:
Write-back scheduler for the dual-write-port ExtWLEN wide register file (WDRs). It arbitrates NReq result producers (e.g. bignum ALU, MAC, load/store) onto write ports A and B every cycle. It rejects lane-overlapping same-register pairs, drives registered addresses, 8-bit lane enables, data and pre-decoded one-hot write strobes, and latches the register file's spurious-WE error.

Parameters:
NReq, 3, number of requesters (2..8)
MaxWait, 4, cycles a valid requester may be refused before forced priority (1..15)
NWdr, 32, number of WDRs
WdrAw, 5, WDR address width
ExtWLEN, 312, register width including integrity bits

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
stall_i  in  1  suppresses all grants this cycle
req_valid_i  in  NReq  request valid per requester
req_ready_o  out  NReq  grant; a transfer occurs when valid&ready
req_addr_i  in  NReq*WdrAw  target WDR per requester
req_lane_i  in  NReq*8  lane (ExtWLEN/8 slice) write mask per requester
req_data_i  in  NReq*ExtWLEN  write data per requester
wr_addr_a_o  out  WdrAw  port A address
wr_en_a_o  out  8  port A lane enables
wr_data_a_o  out  ExtWLEN  port A data
rf_we_a_o  out  NWdr  port A one-hot register strobe
wr_addr_b_o, wr_en_b_o, wr_data_b_o, rf_we_b_o  out  same widths  port B equivalents
rf_we_err_i  in  1  spurious-WE indication from register file
err_o  out  1  sticky error
busy_o  out  1  any req_valid_i high or any output enable nonzero

Behaviour:
- Reset (sync, rst_i high at clk edge): all outputs 0, rr_ptr=0, wait counters=0, err_o=0. Reset overrides stall_i and pending requests. In-flight output writes are dropped.
- req_ready_o is combinational from the current inputs and state. It must not depend on any requester's own ready.
- Candidate order: requesters rr_ptr, rr_ptr+1, … mod NReq. Exception: if any wait counter == MaxWait, the lowest-index such requester is placed first.
- Grant selection, stall_i=0:
  - First valid candidate with nonzero mask -> port A.
  - Next valid candidate with nonzero mask that is not in conflict with port A -> port B.
  - Conflict means equal addr and (lane_a & lane_b) != 0.
  - Same addr with disjoint lanes is legal and both are granted.
- Zero-mask valid requests are granted whenever stall_i=0. They use no port and produce no write.
- Latency: a granted write appears on its port outputs exactly 1 cycle after acceptance.
  - wr_en_x_o = lane mask. rf_we_x_o = onehot(addr) if mask != 0, else 0.
  - Port outputs with no grant: en=0, rf_we=0, addr=0, data=0 (data blanked, not held).
- stall_i=1: req_ready_o=0, next-cycle port enables=0, wait counters still advance.
- rr_ptr: after any port grant, becomes (index of last port-granted requester + 1) mod NReq. Otherwise unchanged.
- Wait counter[r]:
  - Cleared on grant.
  - Incremented when req_valid_i[r]&!req_ready_o[r], saturating at MaxWait.
  - Cleared when valid is low.
- err_o: set when rf_we_err_i=1, or when an internal check finds any output rf_we_x_o that is not one-hot while its en is nonzero. Sticky until reset.
- Output invariant: the same register with overlapping lanes is never driven on A and B in the same cycle.

Test Plan:
1. Reset: rst_i=1 with all req_valid_i=1 -> next cycle all outputs 0, req_ready_o=0 while rst_i held; err_o=0.
2. Dual grant: req0 addr 3 mask 0xFF, req1 addr 7 mask 0x0F, rr_ptr=0 -> ready=3'b011; next cycle A=(3,0xFF,rf_we_a=1<<3), B=(7,0x0F,1<<7); rr_ptr=2.
3. Conflict: req0 and req1 both addr 5, masks 0x03 and 0x02 -> only req0 granted on A, B idle. Same with masks 0x0F/0xF0 -> both granted on addr 5.
4. Round robin: all three requesters continuously valid with distinct addrs -> grant pairs {0,1},{2,0},{1,2},… with no requester waiting more than 1 cycle.
5. Starvation with MaxWait=4: req2 always conflicts with higher-priority continuous req0/req1 -> req2 granted on port A no later than the 5th cycle of waiting.
6. stall_i pulse 2 cycles with valid requests -> ready=0 and port enables 0 for those cycles, grants resume the cycle after. rf_we_err_i one-cycle pulse -> err_o=1 held until rst_i.
